// File: rtl/memory_responder.sv
// memory_responder: word-addressed synchronous memory answering ReadRAM/WriteRAM
// strobes with programmable wait states, a one-cycle completion pulse and an
// idle-only preload port.
module memory_responder #(
  parameter int unsigned ADDR_WIDTH  = 9,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  ReadRAM,
  input  logic                  WriteRAM,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  mem_ready,
  output logic                  busy,
  output logic                  error,
  output logic                  load_ack
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_INIT =
    (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_ACCESS = 3'd2,
    S_DONE   = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_nxt;

  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_data;
  logic                    req_write;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    req_one;
  logic                    req_both;
  logic                    capture;
  logic                    load_ok;
  logic                    mem_we;
  logic                    rd_commit;
  logic                    mem_ready_nxt;
  logic                    busy_nxt;
  logic                    error_nxt;
  logic                    load_ack_nxt;

  // State and wait counter register
  always_ff @(posedge clk) begin
    if (!Reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; strobes only matter in IDLE, DONE and HOLD
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_one   = ReadRAM ^ WriteRAM;
    req_both  = ReadRAM & WriteRAM;
    case (state)
      S_IDLE: begin
        if (req_both) begin
          state_nxt = S_HOLD;
        end else if (req_one) begin
          cnt_nxt   = WAIT_INIT;
          state_nxt = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          state_nxt = S_ACCESS;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_ACCESS: state_nxt = S_DONE;
      S_DONE:   state_nxt = (ReadRAM || WriteRAM) ? S_HOLD : S_IDLE;
      S_HOLD: begin
        if (!ReadRAM && !WriteRAM) begin
          state_nxt = S_IDLE;
        end
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output and datapath control decode
  always_comb begin
    capture       = 1'b0;
    load_ok       = 1'b0;
    mem_we        = 1'b0;
    rd_commit     = 1'b0;
    mem_ready_nxt = 1'b0;
    error_nxt     = 1'b0;
    load_ack_nxt  = 1'b0;
    busy_nxt      = (state_nxt != S_IDLE);
    if (state == S_IDLE) begin
      capture      = req_one;
      error_nxt    = req_both;
      load_ok      = load_en && !ReadRAM && !WriteRAM;
      load_ack_nxt = load_ok;
    end
    if (state == S_ACCESS) begin
      mem_we        = req_write;
      rd_commit     = !req_write;
      mem_ready_nxt = 1'b1;
    end
  end

  // Registered outputs and captured request
  always_ff @(posedge clk) begin
    if (!Reset) begin
      req_addr  <= '0;
      req_data  <= '0;
      req_write <= 1'b0;
      data_out  <= '0;
      mem_ready <= 1'b0;
      busy      <= 1'b0;
      error     <= 1'b0;
      load_ack  <= 1'b0;
    end else begin
      if (capture) begin
        req_addr  <= address;
        req_data  <= data_in;
        req_write <= WriteRAM;
      end
      if (rd_commit) begin
        data_out <= mem[req_addr];
      end
      mem_ready <= mem_ready_nxt;
      busy      <= busy_nxt;
      error     <= error_nxt;
      load_ack  <= load_ack_nxt;
    end
  end

  // Memory array; never cleared, writes suppressed while Reset is asserted
  always_ff @(posedge clk) begin
    if (Reset) begin
      if (mem_we) begin
        mem[req_addr] <= req_data;
      end else if (load_ok) begin
        mem[load_addr] <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: three instances (1, 3 and 0 wait states) share
// stimulus; read results are checked through an expected-data queue.
module tb_memory_responder;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          Reset;
  logic          ReadRAM;
  logic          WriteRAM;
  logic [AW-1:0] address;
  logic [DW-1:0] data_in;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;

  logic [2:0][DW-1:0] dout;
  logic [2:0]         rdy;
  logic [2:0]         bsy;
  logic [2:0]         err;
  logic [2:0]         lack;

  int n_cmp = 0;
  int n_mis = 0;
  logic [DW-1:0] sb_q[$];

  memory_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .Reset(Reset), .ReadRAM(ReadRAM), .WriteRAM(WriteRAM),
    .address(address), .data_in(data_in), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .data_out(dout[0]),
    .mem_ready(rdy[0]), .busy(bsy[0]), .error(err[0]), .load_ack(lack[0]));

  memory_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .Reset(Reset), .ReadRAM(ReadRAM), .WriteRAM(WriteRAM),
    .address(address), .data_in(data_in), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .data_out(dout[1]),
    .mem_ready(rdy[1]), .busy(bsy[1]), .error(err[1]), .load_ack(lack[1]));

  memory_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .Reset(Reset), .ReadRAM(ReadRAM), .WriteRAM(WriteRAM),
    .address(address), .data_in(data_in), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .data_out(dout[2]),
    .mem_ready(rdy[2]), .busy(bsy[2]), .error(err[2]), .load_ack(lack[2]));

  function automatic int ws_of(input int sel);
    case (sel)
      0:       return 1;
      1:       return 3;
      default: return 0;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Preload one word and check the single load_ack pulse
  task automatic do_load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int acks;
    acks = 0;
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    check_eq("load_ack_t", DW'(lack[0]), 1);
    if (lack[0]) acks++;
    load_en = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (lack[0]) acks++;
    end
    check_eq("load_ack_n", DW'(acks), 1);
  endtask

  // Drive one request for 'hold' edges, observe instance 'sel' for a bounded window
  task automatic run_req(input string tag, input int sel, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d, input int hold,
                         input logic [DW-1:0] exp_rd, input logic inj_load);
    int rdy_cnt, rdy_first, err_cnt, lack_cnt, ncyc;
    logic busy1;
    rdy_cnt = 0; rdy_first = -1; err_cnt = 0; lack_cnt = 0; busy1 = 1'b0;
    ncyc = hold + 8;
    if (rd && !wr) sb_q.push_back(exp_rd);
    @(negedge clk);
    ReadRAM = rd; WriteRAM = wr; address = a; data_in = d;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (c == 1) busy1 = bsy[sel];
      if (rdy[sel]) begin
        rdy_cnt++;
        if (rdy_first < 0) rdy_first = c;
        if (sb_q.size() > 0) check_eq({tag, "_data"}, dout[sel], sb_q.pop_front());
      end
      if (err[sel]) err_cnt++;
      if (lack[sel]) lack_cnt++;
      if (c == hold) begin
        ReadRAM = 1'b0; WriteRAM = 1'b0;
        address = AW'($urandom); data_in = $urandom;
      end
      if (inj_load && c == 1) begin
        load_en = 1'b1; load_addr = AW'(5); load_data = 32'h9;
      end
      if (inj_load && c == 2) load_en = 1'b0;
    end
    check_eq({tag, "_busy_start"}, DW'(busy1), 1);
    check_eq({tag, "_busy_end"}, DW'(bsy[sel]), 0);
    if (rd && wr) begin
      check_eq({tag, "_ready_cnt"}, DW'(rdy_cnt), 0);
      check_eq({tag, "_error_cnt"}, DW'(err_cnt), 1);
    end else begin
      check_eq({tag, "_ready_cnt"}, DW'(rdy_cnt), 1);
      check_eq({tag, "_ready_lat"}, DW'(rdy_first), DW'(ws_of(sel) + 2));
      check_eq({tag, "_error_cnt"}, DW'(err_cnt), 0);
    end
    check_eq({tag, "_load_ack"}, DW'(lack_cnt), 0);
    check_eq({tag, "_sb_left"}, DW'(sb_q.size()), 0);
    sb_q.delete();
  endtask

  initial begin
    Reset = 1'b0; ReadRAM = 1'b0; WriteRAM = 1'b0; address = '0; data_in = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check_eq("rst_dout", dout[s], 0);
      check_eq("rst_ready", DW'(rdy[s]), 0);
      check_eq("rst_busy", DW'(bsy[s]), 0);
      check_eq("rst_error", DW'(err[s]), 0);
      check_eq("rst_load_ack", DW'(lack[s]), 0);
    end
    Reset = 1'b1;

    do_load(AW'('h020), 32'h0);
    do_load(AW'('h005), 32'h0);
    do_load(AW'('h003), 32'h55);
    do_load(AW'('h001), 32'h7);
    do_load(AW'('h00A), 32'hDEADBEEF);

    run_req("pre_rd", 0, 1'b1, 1'b0, AW'('h00A), '0, 4, 32'hDEADBEEF, 1'b0);

    run_req("wr", 0, 1'b0, 1'b1, AW'('h1FF), 32'h12345678, 1, '0, 1'b0);
    check_eq("wr_keep_dout", dout[0], 32'hDEADBEEF);
    run_req("raw", 0, 1'b1, 1'b0, AW'('h1FF), '0, 1, 32'h12345678, 1'b0);

    run_req("ill", 0, 1'b1, 1'b1, AW'('h003), '0, 2, '0, 1'b0);
    run_req("ill_rd", 0, 1'b1, 1'b0, AW'('h003), '0, 1, 32'h55, 1'b0);

    // Reset during the second WAIT cycle of the 3-wait-state instance
    @(negedge clk);
    WriteRAM = 1'b1; address = AW'('h020); data_in = 32'hFFFFFFFF;
    @(negedge clk);
    WriteRAM = 1'b0;
    @(negedge clk);
    Reset = 1'b0;
    @(negedge clk);
    check_eq("abort_dout", dout[1], 0);
    check_eq("abort_ready", DW'(rdy[1]), 0);
    check_eq("abort_busy", DW'(bsy[1]), 0);
    check_eq("abort_error", DW'(err[1]), 0);
    check_eq("abort_load_ack", DW'(lack[1]), 0);
    Reset = 1'b1;
    repeat (2) @(negedge clk);
    run_req("abort_rd", 1, 1'b1, 1'b0, AW'('h020), '0, 1, 32'h0, 1'b0);

    run_req("zws", 2, 1'b1, 1'b0, AW'('h001), '0, 1, 32'h7, 1'b0);

    run_req("ld_busy", 0, 1'b1, 1'b0, AW'('h00A), '0, 2, 32'hDEADBEEF, 1'b1);
    run_req("ld_rd", 0, 1'b1, 1'b0, AW'('h005), '0, 1, 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
